rom_arbiter: RTL and testbench

//  Shares the single program ROM read port between the instruction fetcher and a data-read requester
//  (constant/table loads). Each port has a req/gnt/valid handshake.
//  The fetch side's gnt pulse is the fetcher's rom_rd_garant input. Sits between the CPU fetch/load

---
 rtl/rom_arbiter.sv | 147 ++++++++++++++
 tb/tb_rom_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one program ROM read port between the fetch and data-read requesters.
// Define ROM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority with a starvation counter.
module rom_arbiter #(
    parameter int DATA_W     = 14,
    parameter int ADDR_W     = 12,
    parameter int ROM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic [DATA_W-1:0] f_data,
    output logic              f_valid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_data,
    output logic              d_valid,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              winner_d, winner_d_next;
    logic              pick_d;
    logic              f_gnt_next, d_gnt_next, f_valid_next, d_valid_next, rom_rd_next;
    logic [DATA_W-1:0] f_data_next, d_data_next;
    logic [ADDR_W-1:0] rom_addr_next;

`ifdef ROM_ARB_RR_EN
    logic last_d, last_d_next;

    // On a tie the requester that was not granted last goes first.
    assign pick_d = d_req && (!f_req || !last_d);
`else
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] starve_cnt, starve_cnt_next;

    // Fetch wins ties until data has been passed over STARVE_MAX times in a row.
    assign pick_d = d_req && (!f_req || starve_cnt == SC_W'(STARVE_MAX));
`endif

    assign busy = (state == ACCESS);

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        winner_d_next = winner_d;
        f_gnt_next    = 1'b0;
        d_gnt_next    = 1'b0;
        f_valid_next  = 1'b0;
        d_valid_next  = 1'b0;
        f_data_next   = f_data;
        d_data_next   = d_data;
        rom_rd_next   = rom_rd;
        rom_addr_next = rom_addr;
`ifdef ROM_ARB_RR_EN
        last_d_next   = last_d;
`else
        starve_cnt_next = starve_cnt;
`endif
        case (state)
            IDLE: begin
`ifndef ROM_ARB_RR_EN
                if (!d_req || pick_d)
                    starve_cnt_next = '0;
                else if (f_req && starve_cnt != SC_W'(STARVE_MAX))
                    starve_cnt_next = starve_cnt + SC_W'(1);
`endif
                if (f_req || d_req) begin
                    winner_d_next = pick_d;
                    rom_addr_next = pick_d ? d_addr : f_addr;
                    rom_rd_next   = 1'b1;
                    f_gnt_next    = !pick_d;
                    d_gnt_next    = pick_d;
                    cnt_next      = 4'(ROM_LAT - 1);
                    state_next    = ACCESS;
`ifdef ROM_ARB_RR_EN
                    last_d_next   = pick_d;
`endif
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    if (winner_d) begin
                        d_data_next  = rom_data;
                        d_valid_next = 1'b1;
                    end else begin
                        f_data_next  = rom_data;
                        f_valid_next = 1'b1;
                    end
                    rom_rd_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            winner_d <= 1'b0;
            f_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            f_valid  <= 1'b0;
            d_valid  <= 1'b0;
            f_data   <= '0;
            d_data   <= '0;
            rom_rd   <= 1'b0;
            rom_addr <= '0;
`ifdef ROM_ARB_RR_EN
            last_d   <= 1'b1;
`else
            starve_cnt <= '0;
`endif
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            winner_d <= winner_d_next;
            f_gnt    <= f_gnt_next;
            d_gnt    <= d_gnt_next;
            f_valid  <= f_valid_next;
            d_valid  <= d_valid_next;
            f_data   <= f_data_next;
            d_data   <= d_data_next;
            rom_rd   <= rom_rd_next;
            rom_addr <= rom_addr_next;
`ifdef ROM_ARB_RR_EN
            last_d   <= last_d_next;
`else
            starve_cnt <= starve_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed vector table plus hand sequences for rom_arbiter with a latency-checked ROM model.
module tb_rom_arbiter;

    localparam int DATA_W     = 14;
    localparam int ADDR_W     = 12;
    localparam int ROM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              f_req, d_req;
    logic [ADDR_W-1:0] f_addr, d_addr;
    logic              f_gnt, d_gnt, f_valid, d_valid, rom_rd, busy;
    logic [DATA_W-1:0] f_data, d_data, rom_data;
    logic [ADDR_W-1:0] rom_addr;

    int checks   = 0;
    int failures = 0;
    int rd_age;

    rom_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_data(f_data), .f_valid(f_valid),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_data(d_data), .d_valid(d_valid),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // ROM model: correct data only once rom_rd has been held for ROM_LAT cycles, garbage before.
    always @(posedge clk or posedge reset) begin
        if (reset)       rd_age <= 0;
        else if (rom_rd) rd_age <= rd_age + 1;
        else             rd_age <= 0;
    end
    assign rom_data = (rom_rd && rd_age == ROM_LAT - 1) ? ({2'b00, rom_addr} ^ 14'h1A0) : 14'h3FFF;

    typedef struct {
        logic              f_req;
        logic [ADDR_W-1:0] f_addr;
        logic              d_req;
        logic [ADDR_W-1:0] d_addr;
        logic              f_gnt, d_gnt, f_valid, d_valid;
        logic [DATA_W-1:0] f_data, d_data;
        logic              rom_rd;
        logic [ADDR_W-1:0] rom_addr;
        logic              busy;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic fr, input logic [ADDR_W-1:0] fa,
                                 input logic dr, input logic [ADDR_W-1:0] da);
        f_req  = fr;
        f_addr = fa;
        d_req  = dr;
        d_addr = da;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t  vecs[12];
    string order;
    string exp_order;
    int    k;

    initial begin
        vecs[0]  = '{1'b1,12'h005,1'b0,12'h000, 1'b1,1'b0,1'b0,1'b0,14'h000,14'h000,1'b1,12'h005,1'b1};
        vecs[1]  = '{1'b0,12'h005,1'b0,12'h000, 1'b0,1'b0,1'b0,1'b0,14'h000,14'h000,1'b1,12'h005,1'b1};
        vecs[2]  = '{1'b0,12'h005,1'b0,12'h000, 1'b0,1'b0,1'b1,1'b0,14'h1A5,14'h000,1'b0,12'h005,1'b0};
        vecs[3]  = '{1'b0,12'h000,1'b1,12'h07A, 1'b0,1'b1,1'b0,1'b0,14'h1A5,14'h000,1'b1,12'h07A,1'b1};
        vecs[4]  = '{1'b0,12'h000,1'b0,12'h07A, 1'b0,1'b0,1'b0,1'b0,14'h1A5,14'h000,1'b1,12'h07A,1'b1};
        vecs[5]  = '{1'b0,12'h000,1'b0,12'h07A, 1'b0,1'b0,1'b0,1'b1,14'h1A5,14'h1DA,1'b0,12'h07A,1'b0};
        vecs[6]  = '{1'b1,12'h030,1'b1,12'h040, 1'b1,1'b0,1'b0,1'b0,14'h1A5,14'h1DA,1'b1,12'h030,1'b1};
        vecs[7]  = '{1'b0,12'h030,1'b1,12'h040, 1'b0,1'b0,1'b0,1'b0,14'h1A5,14'h1DA,1'b1,12'h030,1'b1};
        vecs[8]  = '{1'b0,12'h030,1'b1,12'h040, 1'b0,1'b0,1'b1,1'b0,14'h190,14'h1DA,1'b0,12'h030,1'b0};
        vecs[9]  = '{1'b0,12'h030,1'b1,12'h040, 1'b0,1'b1,1'b0,1'b0,14'h190,14'h1DA,1'b1,12'h040,1'b1};
        vecs[10] = '{1'b0,12'h000,1'b0,12'h040, 1'b0,1'b0,1'b0,1'b0,14'h190,14'h1DA,1'b1,12'h040,1'b1};
        vecs[11] = '{1'b0,12'h000,1'b0,12'h040, 1'b0,1'b0,1'b0,1'b1,14'h190,14'h1E0,1'b0,12'h040,1'b0};

        doReset();
        checkOutput("rst f_gnt",    32'(f_gnt),    32'h0);
        checkOutput("rst d_gnt",    32'(d_gnt),    32'h0);
        checkOutput("rst f_valid",  32'(f_valid),  32'h0);
        checkOutput("rst d_valid",  32'(d_valid),  32'h0);
        checkOutput("rst f_data",   32'(f_data),   32'h0);
        checkOutput("rst d_data",   32'(d_data),   32'h0);
        checkOutput("rst rom_rd",   32'(rom_rd),   32'h0);
        checkOutput("rst rom_addr", 32'(rom_addr), 32'h0);
        checkOutput("rst busy",     32'(busy),     32'h0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req, vecs[i].d_addr);
            checkOutput($sformatf("v%0d f_gnt", i),    32'(f_gnt),    32'(vecs[i].f_gnt));
            checkOutput($sformatf("v%0d d_gnt", i),    32'(d_gnt),    32'(vecs[i].d_gnt));
            checkOutput($sformatf("v%0d f_valid", i),  32'(f_valid),  32'(vecs[i].f_valid));
            checkOutput($sformatf("v%0d d_valid", i),  32'(d_valid),  32'(vecs[i].d_valid));
            checkOutput($sformatf("v%0d f_data", i),   32'(f_data),   32'(vecs[i].f_data));
            checkOutput($sformatf("v%0d d_data", i),   32'(d_data),   32'(vecs[i].d_data));
            checkOutput($sformatf("v%0d rom_rd", i),   32'(rom_rd),   32'(vecs[i].rom_rd));
            checkOutput($sformatf("v%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].rom_addr));
            checkOutput($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].busy));
        end

        // Both requesters held: grant order and spacing.
        doReset();
        order = "";
`ifdef ROM_ARB_RR_EN
        exp_order = "FDFDFDFDFD";
`else
        exp_order = "FFFFDFFFFD";
`endif
        f_req = 1'b1; f_addr = 12'h011; d_req = 1'b1; d_addr = 12'h022;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (f_gnt || d_gnt) begin
                checkOutput($sformatf("t2 gnt spacing @%0d", i), 32'(i % 3), 32'h0);
                order = {order, (d_gnt ? "D" : "F")};
            end
            if (d_valid) checkOutput("t2 d_data", 32'(d_data), 32'h182);
            if (f_valid) checkOutput("t2 f_data", 32'(f_data), 32'h1B1);
            checkOutput("t2 exclusive", 32'((f_gnt && d_gnt) || (f_valid && d_valid)), 32'h0);
        end
        checks++;
        if (order != exp_order) begin
            failures++;
            $display("[TB] FAIL t2 order: got %s expected %s", order, exp_order);
        end
        applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
        repeat (3) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);

        // Reset asserted between edges 1 and 2 of an access.
        applyStimulus(1'b1, 12'h0AA, 1'b0, 12'h000);
        checkOutput("t4 f_gnt", 32'(f_gnt), 32'h1);
        applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
        checkOutput("t4 busy pre", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("t4 rom_rd async", 32'(rom_rd), 32'h0);
        checkOutput("t4 busy async",   32'(busy),   32'h0);
        checkOutput("t4 f_gnt async",  32'(f_gnt),  32'h0);
        checkOutput("t4 f_data async", 32'(f_data), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
            checkOutput("t4 no valid", 32'(f_valid || d_valid), 32'h0);
        end
        applyStimulus(1'b1, 12'h010, 1'b0, 12'h000);
        checkOutput("t4 regrant", 32'(f_gnt), 32'h1);
        f_req = 1'b0;
        applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
        checkOutput("t4 valid early", 32'(f_valid), 32'h0);
        applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
        checkOutput("t4 f_valid", 32'(f_valid), 32'h1);
        checkOutput("t4 f_data",  32'(f_data),  32'h1B0);

        // d_req pulsed for one cycle while a fetch is in ACCESS.
        applyStimulus(1'b1, 12'h033, 1'b0, 12'h000);
        applyStimulus(1'b0, 12'h000, 1'b1, 12'h044);
        checkOutput("t5 d_gnt pulse", 32'(d_gnt), 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
            checkOutput("t5 d_gnt",   32'(d_gnt),   32'h0);
            checkOutput("t5 d_valid", 32'(d_valid), 32'h0);
            if (i == 0) checkOutput("t5 f_data", 32'(f_data), 32'h193);
        end
`ifndef ROM_ARB_RR_EN
        checkOutput("t5 starve_cnt", 32'(dut.starve_cnt), 32'h0);
`endif

        // Fetch held alone, address advancing after each grant.
        k = 0;
        f_req = 1'b1; f_addr = 12'h100; d_req = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("t6 f_gnt @%0d", i),   32'(f_gnt),   32'(i % 3 == 0));
            checkOutput($sformatf("t6 f_valid @%0d", i), 32'(f_valid), 32'(i % 3 == 2));
            if (i % 3 == 0) begin
                k = i / 3;
                checkOutput("t6 rom_addr", 32'(rom_addr), 32'h100 + 32'(k));
                f_addr = 12'(12'h100 + k + 1);
            end
            if (i % 3 == 2)
                checkOutput("t6 f_data", 32'(f_data), (32'h100 + 32'(k)) ^ 32'h1A0);
        end
        f_req = 1'b0;
        repeat (3) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
